// File: rtl/if_prefetch_unit.sv
// ----------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch front end. It generates PCs, reads a synchronous
// instruction ROM that has one cycle of read latency, and holds the returned
// words in a small prefetch queue. Decode takes them from the queue through a
// valid/ready handshake. Any control-flow change arrives as one redirect:
// the redirect flushes the queue, squashes the response that is in flight,
// and restarts fetch at the target.
//
// Parameters
//   ISA_WIDTH   instruction / PC width
//   ADDR_WIDTH  ROM word-address width (ROM address = PC[ADDR_WIDTH+1:2])
//   RESET_PC    PC loaded on reset
//   Q_DEPTH     prefetch queue entries (power of two, >= 2)
//
// Ports
//   clock           single clock, rising edge
//   reset           asynchronous, active-low reset
//   redirect_valid  control-flow change this cycle
//   redirect_pc     redirect target
//   imem_en         ROM read request (combinational)
//   imem_addr       ROM word address (combinational)
//   imem_rdata      ROM data, valid the cycle after imem_en
//   out_valid       queue head holds an instruction
//   out_ready       decode accepts the head
//   out_instr       head instruction
//   out_pc          head PC
//   out_link_addr   head PC + 4
//   misalign_err    sticky misaligned-redirect flag
//
// Optional feature: define IF_MISALIGN_CHECK_EN to flag misaligned redirect
// targets and halt fetch until an aligned redirect arrives. Without the
// macro, the two low bits of the target are forced to zero and misalign_err
// stays 0.
// ----------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int unsigned          ISA_WIDTH  = 32,
    parameter int unsigned          ADDR_WIDTH = 14,
    parameter logic [ISA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned          Q_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ISA_WIDTH-1:0]  redirect_pc,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [ISA_WIDTH-1:0]  imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ISA_WIDTH-1:0]  out_instr,
    output logic [ISA_WIDTH-1:0]  out_pc,
    output logic [ISA_WIDTH-1:0]  out_link_addr,
    output logic                  misalign_err
);

    localparam int unsigned          PTR_W     = $clog2(Q_DEPTH);
    localparam int unsigned          CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]       DEPTH_L   = (CNT_W + 1)'(Q_DEPTH);
    localparam logic [ISA_WIDTH-1:0] WORD_STEP = ISA_WIDTH'(4);

    logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [ISA_WIDTH-1:0] tag_q, tag_d;

    logic [ISA_WIDTH-1:0] q_instr_q [Q_DEPTH];
    logic [ISA_WIDTH-1:0] q_pc_q    [Q_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Last head seen; shown while the queue is empty so the head outputs
    // do not wander onto stale storage.
    logic [ISA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [ISA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [ISA_WIDTH-1:0] hold_link_q, hold_link_d;

    logic [ISA_WIDTH-1:0] target_pc;
    logic                 halt;
    logic [CNT_W:0]       occ;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [ISA_WIDTH-1:0] head_instr;
    logic [ISA_WIDTH-1:0] head_pc;

    // ------------------------------------------------------------------
    // Redirect target handling
    // ------------------------------------------------------------------
`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign target_pc    = redirect_pc;
    assign halt         = misalign_q;
    assign misalign_err = misalign_q;

    // Each redirect overwrites the flag. An aligned target therefore clears
    // it and a misaligned one sets it.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_pc           = {redirect_pc[ISA_WIDTH-1:2], 2'b00};
    assign halt                = 1'b0;
    assign misalign_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Issue / response / pop decisions
    // ------------------------------------------------------------------
    // Occupancy counts the in-flight word. A response always has a free slot
    // waiting for it, so a push can never overflow the queue.
    assign occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue = reset && !redirect_valid && !halt && (occ < DEPTH_L);
    assign push  = inflight_q && !redirect_valid;
    assign pop   = out_valid && out_ready && !redirect_valid;

    assign imem_en   = issue;
    assign imem_addr = reset ? fetch_pc_q[ADDR_WIDTH+1:2] : '0;

    assign head_instr = q_instr_q[rd_ptr_q];
    assign head_pc    = q_pc_q[rd_ptr_q];

    assign out_valid     = (count_q != '0);
    assign out_instr     = out_valid ? head_instr : hold_instr_q;
    assign out_pc        = out_valid ? head_pc : hold_pc_q;
    assign out_link_addr = out_valid ? (head_pc + WORD_STEP) : hold_link_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = issue;
        tag_d        = tag_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_link_d  = hold_link_q;

        if (out_valid) begin
            hold_instr_d = head_instr;
            hold_pc_d    = head_pc;
            hold_link_d  = head_pc + WORD_STEP;
        end

        if (redirect_valid) begin
            // A redirect overrides a pop in the same cycle. Flushing the
            // queue makes that pop irrelevant.
            fetch_pc_d = target_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + WORD_STEP;
                tag_d      = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            hold_link_q  <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            tag_q        <= tag_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_link_q  <= hold_link_d;
        end
    end

    // Queue storage needs no reset: only entries below count_q are ever
    // shown, and each of them was written by a push.
    always_ff @(posedge clock) begin
        if (push) begin
            q_instr_q[wr_ptr_q] <= imem_rdata;
            q_pc_q[wr_ptr_q]    <= tag_q;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_link_addr;
    logic        misalign_err;

    logic [31:0] rom_q = '0;
    int n_cmp = 0;
    int n_bad = 0;

    if_prefetch_unit #(
        .ISA_WIDTH (32),
        .ADDR_WIDTH(14),
        .RESET_PC  (32'h0000_0000),
        .Q_DEPTH   (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_link_addr (out_link_addr),
        .misalign_err  (misalign_err)
    );

    always #5 clock = ~clock;

    // Synchronous ROM with one cycle of latency: word k holds 0x1000_0000 + k
    always @(posedge clock) if (imem_en) rom_q <= 32'h1000_0000 + 32'(imem_addr);
    assign imem_rdata = rom_q;

    function automatic logic [31:0] rom_of(input logic [31:0] pc);
        rom_of = 32'h1000_0000 + {18'd0, pc[15:2]};
    endfunction

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    // Holds reset for two edges, then releases it; the caller is in cycle 0.
    task automatic restart(input logic rdy);
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = rdy;
        next_cyc();
        next_cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL rst_imem_en got=%b exp=0", imem_en); end
        n_cmp++; if (imem_addr !== 14'd0) begin n_bad++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
        n_cmp++; if (out_instr !== 32'd0) begin n_bad++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        n_cmp++; if (out_pc !== 32'd0) begin n_bad++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
        n_cmp++; if (out_link_addr !== 32'd0) begin n_bad++; $display("FAIL rst_link got=%h exp=0", out_link_addr); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
    endtask

    task automatic test_latency();
        logic [31:0] e;
        restart(1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 0) begin
                n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 14'd0) begin n_bad++; $display("FAIL lat_first_issue got en=%b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
            end
            if (c < 2) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early_valid c=%0d got=%b exp=0", c, out_valid); end
            end else begin
                e = 32'(4 * (c - 2));
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== e) begin n_bad++; $display("FAIL lat_stream c=%0d got v=%b pc=%h exp v=1 pc=%h", c, out_valid, out_pc, e); end
                n_cmp++; if (out_instr !== rom_of(e) || out_link_addr !== e + 32'd4) begin n_bad++; $display("FAIL lat_data c=%0d got i=%h l=%h exp i=%h l=%h", c, out_instr, out_link_addr, rom_of(e), e + 32'd4); end
            end
            next_cyc();
        end
    endtask

    task automatic test_backpressure();
        int issues;
        logic [31:0] e;
        issues = 0;
        restart(1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (imem_en) issues++;
            if (c == 9) begin
                n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL bp_full_en got=%b exp=0", imem_en); end
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin n_bad++; $display("FAIL bp_head_hold got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
            end
            next_cyc();
        end
        n_cmp++; if (issues != 4) begin n_bad++; $display("FAIL bp_issue_count got=%0d exp=4", issues); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            e = 32'(4 * k);
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== e) begin n_bad++; $display("FAIL bp_drain k=%0d got v=%b pc=%h exp v=1 pc=%h", k, out_valid, out_pc, e); end
            n_cmp++; if (out_instr !== rom_of(e)) begin n_bad++; $display("FAIL bp_drain_instr k=%0d got=%h exp=%h", k, out_instr, rom_of(e)); end
            next_cyc();
        end
    endtask

    // Redirect while the queue holds 8,C,10,14 and decode is stalled.
    task automatic test_redirect();
        restart(1'b1);
        for (int c = 0; c < 4; c++) next_cyc();
        out_ready = 1'b0;
        for (int c = 4; c < 10; c++) next_cyc();
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || imem_en !== 1'b0) begin n_bad++; $display("FAIL redir_pre got v=%b pc=%h en=%b exp v=1 pc=8 en=0", out_valid, out_pc, imem_en); end
        next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clock);
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL redir_en_n got=%b exp=0", imem_en); end
        next_cyc();
        redirect_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 14'h10) begin n_bad++; $display("FAIL redir_n1 got v=%b en=%b addr=%h exp v=0 en=1 addr=10", out_valid, imem_en, imem_addr); end
        next_cyc();
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_n2 got v=%b exp=0", out_valid); end
        next_cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * k) || out_instr !== rom_of(32'h40 + 32'(4 * k))) begin n_bad++; $display("FAIL redir_stream k=%0d got v=%b pc=%h i=%h exp pc=%h", k, out_valid, out_pc, out_instr, 32'h40 + 32'(4 * k)); end
            next_cyc();
        end
    endtask

    task automatic test_redirect_pop();
        restart(1'b1);
        for (int c = 0; c < 6; c++) next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0080;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rp_head_present got=%b exp=1", out_valid); end
        next_cyc();
        redirect_valid = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(negedge clock);
            if (k < 3) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rp_gap k=%0d got=%b exp=0", k, out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h80 + 32'(4 * (k - 3))) begin n_bad++; $display("FAIL rp_stream k=%0d got v=%b pc=%h exp pc=%h", k, out_valid, out_pc, 32'h80 + 32'(4 * (k - 3))); end
            end
            next_cyc();
        end
    endtask

    task automatic test_reset_midstream();
        restart(1'b1);
        for (int c = 0; c < 5; c++) next_cyc();
        @(negedge clock);
        n_cmp++; if (imem_en !== 1'b1) begin n_bad++; $display("FAIL mr_inflight got en=%b exp=1", imem_en); end
        next_cyc();
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 14'd0) begin n_bad++; $display("FAIL mr_ctrl got v=%b en=%b addr=%h exp 0", out_valid, imem_en, imem_addr); end
        n_cmp++; if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_link_addr !== 32'd0) begin n_bad++; $display("FAIL mr_head got pc=%h i=%h l=%h exp 0", out_pc, out_instr, out_link_addr); end
        next_cyc();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c < 2) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_gap c=%0d got=%b exp=0", c, out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_instr !== rom_of(32'(4 * (c - 2)))) begin n_bad++; $display("FAIL mr_restart c=%0d got v=%b pc=%h i=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'(4 * (c - 2))); end
            end
            next_cyc();
        end
    endtask

    task automatic test_misalign();
        restart(1'b1);
        for (int c = 0; c < 4; c++) next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0042;
        next_cyc();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        for (int k = 1; k < 5; k++) begin
            @(negedge clock);
            n_cmp++; if (misalign_err !== 1'b1 || imem_en !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ma_halt k=%0d got err=%b en=%b v=%b exp err=1 en=0 v=0", k, misalign_err, imem_en, out_valid); end
            next_cyc();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0044;
        @(negedge clock);
        n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL ma_sticky got=%b exp=1", misalign_err); end
        next_cyc();
        redirect_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clock);
            if (k == 1) begin
                n_cmp++; if (misalign_err !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 14'h11) begin n_bad++; $display("FAIL ma_clear got err=%b en=%b addr=%h exp err=0 en=1 addr=11", misalign_err, imem_en, imem_addr); end
            end
            if (k >= 3) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h44 + 32'(4 * (k - 3))) begin n_bad++; $display("FAIL ma_resume k=%0d got v=%b pc=%h exp pc=%h", k, out_valid, out_pc, 32'h44 + 32'(4 * (k - 3))); end
            end
            next_cyc();
        end
`else
        for (int k = 1; k < 6; k++) begin
            @(negedge clock);
            n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL ma_tied k=%0d got=%b exp=0", k, misalign_err); end
            if (k >= 3) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * (k - 3)) || out_instr !== rom_of(32'h40 + 32'(4 * (k - 3)))) begin n_bad++; $display("FAIL ma_forced k=%0d got v=%b pc=%h i=%h exp pc=%h", k, out_valid, out_pc, out_instr, 32'h40 + 32'(4 * (k - 3))); end
            end
            next_cyc();
        end
`endif
    endtask

    // Random redirects and decode stalls against a stream model: accepted
    // instructions must be consecutive words from the last target (reset
    // counts as a redirect to 0), and a redirect in cycle N gives
    // out_valid=0 in N+1, N+2 and out_valid=1 in N+3.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] prev_pc;
        logic        r1, r2, r3;
        logic        prev_valid, prev_pop, prev_redir;
        exp_pc = 32'd0;
        r1 = 1'b1; r2 = 1'b0; r3 = 1'b0;
        prev_valid = 1'b0; prev_pop = 1'b0; prev_redir = 1'b0; prev_pc = '0;
        restart(1'b0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 3) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else tgt = 32'($urandom_range(0, 1023)) << 2;
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc = tgt;
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clock);
            if (redirect_valid) begin
                n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL rnd_redir_en c=%0d got=%b exp=0", c, imem_en); end
            end
            if (r1 || r2) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush c=%0d got v=%b exp=0", c, out_valid); end
            end else if (r3) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_n3 c=%0d got v=%b pc=%h exp v=1 pc=%h", c, out_valid, out_pc, exp_pc); end
            end
            if (prev_valid && !prev_pop && !prev_redir) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== prev_pc) begin n_bad++; $display("FAIL rnd_hold c=%0d got v=%b pc=%h exp v=1 pc=%h", c, out_valid, out_pc, prev_pc); end
            end
            if (out_valid && out_ready && !redirect_valid) begin
                n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, out_pc, exp_pc); end
                n_cmp++; if (out_instr !== rom_of(exp_pc) || out_link_addr !== exp_pc + 32'd4) begin n_bad++; $display("FAIL rnd_data c=%0d got i=%h l=%h exp i=%h l=%h", c, out_instr, out_link_addr, rom_of(exp_pc), exp_pc + 32'd4); end
                exp_pc = exp_pc + 32'd4;
            end
            n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL rnd_misalign c=%0d got=%b exp=0", c, misalign_err); end
            prev_valid = out_valid;
            prev_pc    = out_pc;
            prev_pop   = out_valid && out_ready;
            prev_redir = redirect_valid;
            if (redirect_valid) exp_pc = tgt;
            r3 = r2; r2 = r1; r1 = redirect_valid;
            next_cyc();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_reset_midstream();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch front end that supersedes the single-PC fetch block. It decouples PC generation from decode with a small prefetch queue and drives a synchronous instruction ROM with one-cycle read latency. Control flow (beq/bne taken, j/jal, jr) arrives as one consolidated redirect. Decode consumes instructions through a valid/ready handshake, and each instruction carries its PC and link address (pc+4).

Parameters:
ISA_WIDTH, 32, instruction and PC width in bits
ADDR_WIDTH, 14, ROM word-address width; ROM address is PC[ADDR_WIDTH+1:2]
RESET_PC, 32'h0000_0000, PC loaded on reset
Q_DEPTH, 4, prefetch queue entries; power of two, minimum 2

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
redirect_valid  in  1  control-flow change this cycle
redirect_pc  in  ISA_WIDTH  target PC (branch result, jump target, or $31 for jr)
imem_en  out  1  ROM read request this cycle
imem_addr  out  ADDR_WIDTH  ROM word address
imem_rdata  in  ISA_WIDTH  ROM data, valid the cycle after imem_en
out_valid  out  1  queue head holds an instruction
out_ready  in  1  decode accepts head
out_instr  out  ISA_WIDTH  head instruction
out_pc  out  ISA_WIDTH  head PC
out_link_addr  out  ISA_WIDTH  head PC+4, used by jal
misalign_err  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, while reset=0): fetch_pc=RESET_PC; queue empty; no request in flight. Outputs: out_valid=0, imem_en=0, imem_addr=0, out_instr=0, out_pc=0, out_link_addr=0, misalign_err=0.
- Issue: imem_en=1 when no redirect is present and (queue occupancy + in-flight count) < Q_DEPTH.
  - imem_addr = fetch_pc[ADDR_WIDTH+1:2]. imem_en and imem_addr are combinational from registered state.
  - On issue, fetch_pc <= fetch_pc+4, and the issued PC is latched as the in-flight tag.
- Response: the cycle after an issue, imem_rdata and the tag are pushed into the queue at the clock edge, unless squashed.
- Latency: first request issues in the first cycle after reset deasserts (cycle 0). Data arrives in cycle 1. out_valid=1 from cycle 2.
- Steady state: one instruction per cycle while out_ready=1.
- Pop: occurs when out_valid && out_ready. Head outputs change only on pop, push into an empty queue, or flush. out_link_addr = out_pc+4 modulo 2^ISA_WIDTH.
- Redirect in cycle N:
  - queue flushed, in-flight response squashed, fetch_pc <= redirect_pc;
  - imem_en=0 in cycle N;
  - target issued in N+1, data returns in N+2, out_valid=1 in N+3.
- Redirect plus pop in the same cycle: redirect wins; the pop has no further effect because the queue is flushed.
- Full: no issue while occupancy+in-flight = Q_DEPTH. A push and a pop in the same cycle on a full queue is legal and keeps the occupancy unchanged.
- Empty: out_valid=0; head outputs hold their last values.
- PC wrap: fetch_pc wraps modulo 2^ISA_WIDTH. ROM address aliases via the truncated bits.
- Reset asserted mid-operation: immediate return to reset state; any in-flight response is discarded.

Optional Feature:
Macro IF_MISALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 is still accepted, and the queue is flushed. misalign_err is set the next cycle, and fetch halts (imem_en=0, out_valid=0). misalign_err stays set until an aligned redirect (which resumes fetch normally) or reset.
- Undefined: redirect_pc[1:0] is forced to 00 and misalign_err is tied to 0.

Test Plan:
- Reset release, ROM word k = 32'h1000_0000+k, out_ready=1 -> out_valid rises 2 cycles after release; out_pc sequence 0,4,8,C one per cycle; out_instr 32'h1000_0000.. ; out_link_addr = out_pc+4.
- out_ready=0 for 10 cycles with Q_DEPTH=4 -> imem_en drops after the queue fills; exactly 4 entries held; on release, PCs 0,4,8,C then 10 with no gap, no duplicate, no loss.
- Redirect to 32'h0000_0040 while the queue is holding PCs 8..14 -> the next out_pc is 40 in cycle N+3; no stale instruction appears.
- Redirect and out_ready=1 in the same cycle with the queue non-empty -> the head is not consumed twice, and the post-redirect stream begins at the target.
- reset=0 for one cycle mid-stream with a request in flight -> outputs at reset values; after release, the stream restarts at RESET_PC; the in-flight data never appears.
- With IF_MISALIGN_CHECK_EN, redirect to 32'h0000_0042 -> misalign_err=1 and fetch halts; a redirect to 32'h0000_0044 clears it and out_pc=44 appears 3 cycles later. Without the macro, the same stimulus fetches from 40.
